// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
//   Deserializes PS/2 device-to-host frames into the 11-bit key event word
//   {toggle, pressed, extended, code[7:0]}. Each completed key event flips
//   bit 10 exactly once. Set-2 prefixes E0 (extended) and F0 (release) fold
//   into flag bits. E1 (Pause) swallows the following 7 bytes.
//
// Ports
//   clk_sys   in   system clock, rising edge
//   RESET_N   in   synchronous active-low reset
//   ps2_clk   in   asynchronous PS/2 clock from the device
//   ps2_dat   in   asynchronous PS/2 data from the device
//   ps2_key   out  event word {toggle, pressed, extended, code}
//   frame_err out  one-cycle pulse when a frame is discarded
//
// Parameters
//   FILTER_LEN   consecutive differing samples needed to flip the filtered clock
//   TIMEOUT_CYC  idle cycles before a partial frame is aborted
//
// Build option
//   PS2_TIMEOUT_EN  when defined, adds a watchdog that aborts stalled frames.

module ps2_key_encoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              fclk_q;
  logic              fclk_dly_q;

  state_e            state_q;
  logic [2:0]        bitcnt_q;
  logic [7:0]        shift_q;
  logic              par_ok_q;

  logic              ext_q, ext_d;
  logic              rel_q, rel_d;
  logic [2:0]        skip_q, skip_d;
  logic [10:0]       key_q, key_d;
  logic              err_q;

  logic              clk_s_c;
  logic              dat_s_c;
  logic              bit_evt_c;
  logic              deliver_c;
  logic              bad_c;
  logic              to_c;
  logic              flush_c;
  logic              filler_c;

  assign clk_s_c   = clk_sync_q[1];
  assign dat_s_c   = dat_sync_q[1];
  // Bit event is the cycle after the filtered clock registered a fall.
  assign bit_evt_c = fclk_dly_q & ~fclk_q;

  assign deliver_c = bit_evt_c && (state_q == ST_STOP) && dat_s_c && par_ok_q;
  assign bad_c     = bit_evt_c && (state_q == ST_STOP) && !(dat_s_c && par_ok_q);
  assign flush_c   = bad_c | to_c;
  assign filler_c  = shift_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  // Two-flop synchronizers and glitch filter on the PS/2 clock.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      fcnt_q     <= '0;
      fclk_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      fclk_dly_q <= fclk_q;
      if (clk_s_c == fclk_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCNT_LAST) begin
        fclk_q <= ~fclk_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  assign to_c = (state_q != ST_IDLE) && !bit_evt_c && (wd_q == WD_W'(TIMEOUT_CYC));

  // Watchdog: counts idle cycles while a frame is in progress.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      wd_q <= '0;
    end else if ((state_q == ST_IDLE) || bit_evt_c) begin
      wd_q <= '0;
    end else if (!to_c) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign to_c = 1'b0;
`endif

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      par_ok_q <= 1'b0;
    end else if (to_c) begin
      state_q <= ST_IDLE;
    end else if (bit_evt_c) begin
      case (state_q)
        ST_IDLE: begin
          // A high "start" bit is line noise and silently ignored.
          if (!dat_s_c) begin
            state_q  <= ST_DATA;
            bitcnt_q <= 3'd0;
          end
        end
        ST_DATA: begin
          shift_q  <= {dat_s_c, shift_q[7:1]};
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_q <= ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_q <= ^{shift_q, dat_s_c};
          state_q  <= ST_STOP;
        end
        ST_STOP: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Prefix stage: folds E0/F0 into flags, handles Pause skip and filler bytes.
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    key_d  = key_q;
    if (flush_c) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = 3'd0;
    end else if (deliver_c) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (shift_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: rel_d = 1'b1;
          8'hE1: begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end
          default: begin
            // Filler bytes are only dropped when no prefix is pending.
            if (!(filler_c && !ext_q && !rel_q)) begin
              key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            end
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= 3'd0;
      key_q  <= 11'd0;
      err_q  <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      skip_q <= skip_d;
      key_q  <= key_d;
      err_q  <= flush_c;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule
